// File: rtl/odometry_pkg.sv
// -----------------------------------------------------------------------------
// odometry_pkg
//   Shared definitions for the CORDIC sin/cos unit of the odometry datapath.
//   - FSM state encoding and the matching debug codes seen on db_estado.
//   - Angle and gain constants (pi, pi/2, K) and the atan(2^-i) table, held
//     with 32 fractional bits. q32_to_frac() rescales them, with rounding, to
//     whatever fixed-point format a WIDTH/GUARD instance uses.
// -----------------------------------------------------------------------------
package odometry_pkg;

    // Three bits leave room for unused encodings, which the FSM recovers from.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREP   = 3'd1,
        ST_ROTATE = 3'd2,
        ST_FINISH = 3'd3
    } cordic_state_t;

    localparam logic [3:0] DBG_IDLE   = 4'h0;
    localparam logic [3:0] DBG_PREP   = 4'h1;
    localparam logic [3:0] DBG_ROTATE = 4'h2;
    localparam logic [3:0] DBG_FINISH = 4'h3;
    localparam logic [3:0] DBG_UNUSED = 4'hF;

    // Master copies of the constants, scaled by 2^32.
    localparam int Q32_FRAC = 32;
    localparam logic signed [63:0] PI_Q32      = 64'sd13493037705;
    localparam logic signed [63:0] HALF_PI_Q32 = 64'sd6746518852;
    localparam logic signed [63:0] K_Q32       = 64'sd2608131496;   // 0.6072529...

    // atan(2^-i), i = 0..31, scaled by 2^32. Beyond i = 16 it is just 2^(32-i).
    localparam int ATAN_ENTRIES = 32;
    localparam logic signed [63:0] ATAN_Q32 [ATAN_ENTRIES] = '{
        64'sd3373259426, 64'sd1991351318, 64'sd1052175346, 64'sd534100635,
        64'sd268086748,  64'sd134174063,  64'sd67103403,   64'sd33553749,
        64'sd16777131,   64'sd8388597,    64'sd4194303,    64'sd2097152,
        64'sd1048576,    64'sd524288,     64'sd262144,     64'sd131072,
        64'sd65536,      64'sd32768,      64'sd16384,      64'sd8192,
        64'sd4096,       64'sd2048,       64'sd1024,       64'sd512,
        64'sd256,        64'sd128,        64'sd64,         64'sd32,
        64'sd16,         64'sd8,          64'sd4,          64'sd2
    };

    // Rescale a 2^32-scaled constant to 'frac' fractional bits, rounding
    // half-up. Only meaningful for frac < 32.
    function automatic logic signed [63:0] q32_to_frac(input logic signed [63:0] value,
                                                       input int frac);
        logic signed [63:0] half;
        half = 64'sd1 <<< (Q32_FRAC - 1 - frac);
        return (value + half) >>> (Q32_FRAC - frac);
    endfunction

endpackage

// File: rtl/cordic_sincos_unit_if.sv
// -----------------------------------------------------------------------------
// cordic_sincos_unit_if
//   Start/done handshake between the odometry controller (master) and the
//   CORDIC sin/cos unit (slave).
//   start      master->slave  one-cycle request, sampled only while idle
//   angle      master->slave  signed heading, Q3.(WIDTH-3) rad
//   busy       slave->master  operation in progress
//   done       slave->master  one-cycle pulse, cos_out/sin_out valid
//   cos_out    slave->master  signed cos, Q2.(WIDTH-2)
//   sin_out    slave->master  signed sin, Q2.(WIDTH-2)
//   db_estado  slave->master  debug state code
// -----------------------------------------------------------------------------
interface cordic_sincos_unit_if #(
    parameter int WIDTH = 16
);
    logic                    start;
    logic signed [WIDTH-1:0] angle;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] cos_out;
    logic signed [WIDTH-1:0] sin_out;
    logic [3:0]              db_estado;

    modport master (
        output start, angle,
        input  busy, done, cos_out, sin_out, db_estado
    );

    modport slave (
        input  start, angle,
        output busy, done, cos_out, sin_out, db_estado
    );
endinterface

// File: rtl/cordic_atan_rom.sv
// -----------------------------------------------------------------------------
// cordic_atan_rom
//   Combinational lookup of atan(2^-i) in the internal z format
//   (ZF fractional bits, IW bits signed), indexed by the iteration counter.
//   idx     in   AW   iteration index i
//   atan_z  out  IW   atan(2^-i) in z format (0 for i >= 32)
// -----------------------------------------------------------------------------
module cordic_atan_rom
    import odometry_pkg::*;
#(
    parameter int IW = 19,
    parameter int ZF = 15,
    parameter int AW = 4
) (
    input  logic [AW-1:0]        idx,
    output logic signed [IW-1:0] atan_z
);

    logic signed [IW-1:0] table_w [2**AW];

    generate
        for (genvar gi = 0; gi < 2**AW; gi++) begin : g_entry
            if (gi < ATAN_ENTRIES) begin : g_val
                localparam logic signed [IW-1:0] ENTRY = IW'(q32_to_frac(ATAN_Q32[gi], ZF));
                assign table_w[gi] = ENTRY;
            end else begin : g_zero
                assign table_w[gi] = '0;
            end
        end
    endgenerate

    assign atan_z = table_w[idx];

endmodule

// File: rtl/cordic_sincos_unit.sv
// -----------------------------------------------------------------------------
// cordic_sincos_unit
//   Iterative rotation-mode CORDIC: on an accepted start it latches the
//   heading angle, folds it into [-pi/2, +pi/2], runs ITER micro-rotations
//   and returns cos/sin with a one-cycle done pulse. Results hold until the
//   next operation completes.
//   clock  in   1     system clock, rising edge
//   reset  in   1     synchronous, active-high; aborts any operation
//   bus    slave      start/angle in; busy/done/cos_out/sin_out/db_estado out
// Timing: start sampled at edge N -> PREP, ITER x ROTATE, FINISH ->
//   done high in cycle N+ITER+2 (an IDLE cycle, so a new start is accepted).
// -----------------------------------------------------------------------------
module cordic_sincos_unit
    import odometry_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 14,
    parameter int GUARD = 2
) (
    input  logic                clock,
    input  logic                reset,
    cordic_sincos_unit_if.slave bus
);

    localparam int IW = WIDTH + GUARD + 1;      // internal x/y/z width
    localparam int ZF = WIDTH - 3 + GUARD;      // z fractional bits
    localparam int XF = WIDTH - 2 + GUARD;      // x/y fractional bits
    localparam int CW = $clog2(WIDTH);          // counter width, covers 0..WIDTH-1

    // pi and pi/2 are taken as the values representable at the input
    // resolution, so that angle == +/-pi folds to exactly z = 0.
    localparam logic signed [IW-1:0] PI_Z          = IW'(q32_to_frac(PI_Q32, WIDTH - 3) <<< GUARD);
    localparam logic signed [IW-1:0] HALF_PI_Z     = IW'(q32_to_frac(HALF_PI_Q32, WIDTH - 3) <<< GUARD);
    localparam logic signed [IW-1:0] NEG_HALF_PI_Z = -HALF_PI_Z;
    localparam logic signed [IW-1:0] K_X           = IW'(q32_to_frac(K_Q32, XF));
    localparam logic signed [IW-1:0] ROUND_HALF    = IW'((2**GUARD) / 2);
    localparam logic signed [IW-1:0] SAT_POS       = IW'(1) <<< (WIDTH - 2);
    localparam logic signed [IW-1:0] SAT_NEG       = -SAT_POS;
    localparam logic [CW-1:0]        LAST_ITER     = CW'(ITER - 1);

    cordic_state_t state_reg, state_next;

    logic signed [WIDTH-1:0] angle_reg;
    logic signed [IW-1:0]    x_reg, y_reg, z_reg;
    logic                    neg_reg;
    logic [CW-1:0]           iter_reg;
    logic signed [WIDTH-1:0] cos_reg, sin_reg;
    logic                    done_reg;

    logic                    busy_w;
    logic [3:0]              db_w;
    logic signed [IW-1:0]    angle_ext;
    logic signed [IW-1:0]    pre_z;
    logic                    pre_neg;
    logic signed [IW-1:0]    atan_z;
    logic signed [IW-1:0]    x_shift, y_shift;
    logic signed [IW-1:0]    x_next, y_next, z_next;
    logic signed [WIDTH-1:0] cos_final, sin_final;

    cordic_atan_rom #(
        .IW (IW),
        .ZF (ZF),
        .AW (CW)
    ) u_atan_rom (
        .idx    (iter_reg),
        .atan_z (atan_z)
    );

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy_w     = 1'b0;
        db_w       = DBG_UNUSED;
        case (state_reg)
            ST_IDLE: begin
                db_w = DBG_IDLE;
                if (bus.start) begin
                    state_next = ST_PREP;
                end
            end
            ST_PREP: begin
                db_w       = DBG_PREP;
                busy_w     = 1'b1;
                state_next = ST_ROTATE;
            end
            ST_ROTATE: begin
                db_w   = DBG_ROTATE;
                busy_w = 1'b1;
                if (iter_reg == LAST_ITER) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                db_w       = DBG_FINISH;
                busy_w     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------ quadrant pre-rotation
    // Angles beyond +/-pi/2 are moved by pi into the CORDIC convergence
    // range; the results are negated at the end to compensate.
    always_comb begin
        angle_ext = IW'(angle_reg) <<< GUARD;
        pre_z     = angle_ext;
        pre_neg   = 1'b0;
        if (angle_ext > HALF_PI_Z) begin
            pre_z   = angle_ext - PI_Z;
            pre_neg = 1'b1;
        end else if (angle_ext < NEG_HALF_PI_Z) begin
            pre_z   = angle_ext + PI_Z;
            pre_neg = 1'b1;
        end
    end

    // ------------------------------------------------------ micro-rotation
    always_comb begin
        x_shift = x_reg >>> iter_reg;
        y_shift = y_reg >>> iter_reg;
        if (!z_reg[IW-1]) begin
            x_next = x_reg - y_shift;
            y_next = y_reg + x_shift;
            z_next = z_reg - atan_z;
        end else begin
            x_next = x_reg + y_shift;
            y_next = y_reg - x_shift;
            z_next = z_reg + atan_z;
        end
    end

    // --------------------------------------------------------- output stage
    // Drop guard bits (round half-up), clamp to +/-1.0, undo the pre-rotation.
    function automatic logic signed [WIDTH-1:0] finish_value(input logic signed [IW-1:0] v,
                                                             input logic negate);
        logic signed [IW-1:0] r;
        r = (v + ROUND_HALF) >>> GUARD;
        if (r > SAT_POS) begin
            r = SAT_POS;
        end else if (r < SAT_NEG) begin
            r = SAT_NEG;
        end
        if (negate) begin
            r = -r;
        end
        return WIDTH'(r);
    endfunction

    always_comb begin
        cos_final = finish_value(x_reg, neg_reg);
        sin_final = finish_value(y_reg, neg_reg);
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            angle_reg <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            neg_reg   <= 1'b0;
            iter_reg  <= '0;
            cos_reg   <= '0;
            sin_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        angle_reg <= bus.angle;
                    end
                end
                ST_PREP: begin
                    x_reg    <= K_X;
                    y_reg    <= '0;
                    z_reg    <= pre_z;
                    neg_reg  <= pre_neg;
                    iter_reg <= '0;
                end
                ST_ROTATE: begin
                    x_reg    <= x_next;
                    y_reg    <= y_next;
                    z_reg    <= z_next;
                    iter_reg <= iter_reg + CW'(1);
                end
                ST_FINISH: begin
                    cos_reg  <= cos_final;
                    sin_reg  <= sin_final;
                    done_reg <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = busy_w;
    assign bus.done      = done_reg;
    assign bus.cos_out   = cos_reg;
    assign bus.sin_out   = sin_reg;
    assign bus.db_estado = db_w;

endmodule

// File: tb/tb_cordic_sincos_unit.sv
// -----------------------------------------------------------------------------
// tb_cordic_sincos_unit
//   Directed and random operations on the CORDIC sin/cos unit. Results are
//   compared with real-valued cos/sin of the angle (scale 8192 in, 16384 out)
//   within +/-4 LSB; handshake signals are checked every cycle of every
//   operation. Cycle k = the cycle following the k-th rising edge after the
//   edge that sampled start (k = 0).
// -----------------------------------------------------------------------------
module tb_cordic_sincos_unit;

    localparam int WIDTH = 16;
    localparam int ITER  = 14;
    localparam int GUARD = 2;
    localparam int TOL   = 4;

    logic clock = 1'b0;
    logic reset;

    int total = 0;
    int bad   = 0;
    int last_cos = 0;
    int last_sin = 0;

    cordic_sincos_unit_if #(.WIDTH(WIDTH)) bus();

    cordic_sincos_unit #(
        .WIDTH (WIDTH),
        .ITER  (ITER),
        .GUARD (GUARD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------ checkers
    task automatic check_int(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp_v);
        logic ok;
        ok = ((obs - exp_v) <= TOL) && ((exp_v - obs) <= TOL);
        total++;
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp_v, TOL);
        end
    endtask

    // ------------------------------------------------------ reference model
    function automatic int ref_cos(input int ang);
        real a;
        a = real'(ang) / 8192.0;
        return int'($cos(a) * 16384.0);
    endfunction

    function automatic int ref_sin(input int ang);
        real a;
        a = real'(ang) / 8192.0;
        return int'($sin(a) * 16384.0);
    endfunction

    // Expected debug code in cycle k of an operation.
    function automatic int exp_db(input int k);
        if (k == 0)        return 1;
        if (k <= ITER)     return 2;
        if (k == ITER + 1) return 3;
        return 0;
    endfunction

    // One operation with per-cycle handshake checks.
    //   prestarted: start for this angle was already sampled at the previous
    //               edge (back-to-back issue) and we are in cycle 0.
    //   dup_cycle : edge index at which a second start (dup_ang) is offered.
    //   chain     : offer the next start in the done cycle and return in
    //               cycle 0 of that next operation.
    task automatic run_op(input string name, input int ang, input bit prestarted,
                          input int dup_cycle, input int dup_ang,
                          input bit chain, input int chain_ang);
        int got_c;
        int got_s;
        int last_k;
        got_c  = 99999;
        got_s  = 99999;
        last_k = chain ? ITER + 2 : ITER + 4;
        if (!prestarted) begin
            @(negedge clock);
            bus.start = 1'b1;
            bus.angle = WIDTH'(ang);
            @(negedge clock);
        end
        bus.start = 1'b0;
        bus.angle = WIDTH'($urandom);
        for (int k = 0; k <= last_k; k++) begin
            check_int($sformatf("%s busy c%0d", name, k), int'(bus.busy), int'(k <= ITER + 1));
            check_int($sformatf("%s done c%0d", name, k), int'(bus.done), int'(k == ITER + 2));
            check_int($sformatf("%s db c%0d", name, k), int'(bus.db_estado), exp_db(k));
            if (bus.done) begin
                got_c = int'(bus.cos_out);
                got_s = int'(bus.sin_out);
            end
            if (chain && k == last_k) begin
                bus.start = 1'b1;
                bus.angle = WIDTH'(chain_ang);
            end else if (k + 1 == dup_cycle) begin
                bus.start = 1'b1;
                bus.angle = WIDTH'(dup_ang);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clock);
        end
        check_near({name, " cos"}, got_c, ref_cos(ang));
        check_near({name, " sin"}, got_s, ref_sin(ang));
        if (!chain) begin
            check_int({name, " cos hold"}, int'(bus.cos_out), got_c);
            check_int({name, " sin hold"}, int'(bus.sin_out), got_s);
        end
        last_cos = got_c;
        last_sin = got_s;
        $display("txn %s angle=%0d cos=%0d sin=%0d ref_cos=%0d ref_sin=%0d",
                 name, ang, got_c, got_s, ref_cos(ang), ref_sin(ang));
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int ang;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.angle = '0;
        repeat (3) @(negedge clock);
        check_int("reset busy", int'(bus.busy), 0);
        check_int("reset done", int'(bus.done), 0);
        check_int("reset db", int'(bus.db_estado), 0);
        check_int("reset cos", int'(bus.cos_out), 0);
        check_int("reset sin", int'(bus.sin_out), 0);
        reset = 1'b0;

        // Directed angles, including the pre-rotation boundaries.
        run_op("zero", 0, 1'b0, -1, 0, 1'b0, 0);
        run_op("half_pi", 12868, 1'b0, -1, 0, 1'b0, 0);
        run_op("neg_quarter_pi", -6434, 1'b0, -1, 0, 1'b0, 0);
        run_op("pos_pi", 25736, 1'b0, -1, 0, 1'b0, 0);
        run_op("neg_pi", -25736, 1'b0, -1, 0, 1'b0, 0);
        run_op("neg_half_pi", -12868, 1'b0, -1, 0, 1'b0, 0);

        // Start offered while busy must be ignored.
        run_op("dup_start", 6434, 1'b0, 5, -12868, 1'b0, 0);

        // Back-to-back: next start issued in the done cycle.
        run_op("chain_a", 20000, 1'b0, -1, 0, 1'b1, -18000);
        run_op("chain_b", -18000, 1'b1, -1, 0, 1'b0, 0);

        // Random angles over [-pi, +pi].
        for (int n = 0; n < 10; n++) begin
            ang = int'($urandom_range(51472, 0)) - 25736;
            run_op($sformatf("rand%0d", n), ang, 1'b0, -1, 0, 1'b0, 0);
        end

        // Reset in the middle of an operation (edge 8).
        @(negedge clock);
        bus.start = 1'b1;
        bus.angle = WIDTH'(9000);
        @(negedge clock);
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                reset = 1'b1;
            end
            @(negedge clock);
        end
        check_int("midreset db", int'(bus.db_estado), 0);
        check_int("midreset busy", int'(bus.busy), 0);
        check_int("midreset cos", int'(bus.cos_out), 0);
        check_int("midreset sin", int'(bus.sin_out), 0);
        check_int("midreset done", int'(bus.done), 0);
        reset = 1'b0;
        for (int k = 0; k < ITER + 4; k++) begin
            @(negedge clock);
            check_int($sformatf("postreset done c%0d", k), int'(bus.done), 0);
            check_int($sformatf("postreset busy c%0d", k), int'(bus.busy), 0);
        end
        $display("txn midreset angle=9000 aborted");

        run_op("after_reset", -3000, 1'b0, -1, 0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
